// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready payload handshake between two pipeline stages
interface pipe_stage_buf_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  modport master (output flush, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, occupancy);
  modport slave  (input  flush, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, occupancy);
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: registered pipeline stage with optional two-entry skid and masked flush
module pipe_stage_buf #(
  parameter int               WIDTH    = 32,
  parameter bit               SKID     = 1,
  parameter logic [WIDTH-1:0] CLR_MASK = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
  input logic              clk,
  input logic              rst_n,
  pipe_stage_buf_if.slave  bus
);
  logic [WIDTH-1:0] main_q, skid_q;
  logic             main_v, skid_v, in_fire, out_fire;
  // with SKID the ready depends only on the skid flop, cutting the out_ready->in_ready path
  assign bus.in_ready  = SKID ? !skid_v : (bus.out_ready | !main_v);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = main_v & bus.out_ready;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_q;
  assign bus.occupancy = {1'b0, main_v} + {1'b0, skid_v};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else if (bus.flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= main_q & ~CLR_MASK;
      skid_q <= skid_q & ~CLR_MASK;
    end else if (skid_v) begin
      if (out_fire) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (SKID && in_fire && main_v && !out_fire) begin
      skid_q <= bus.in_data;
      skid_v <= 1'b1;
    end else if (in_fire) begin
      main_q <= bus.in_data;
      main_v <= 1'b1;
    end else if (out_fire) begin
      main_v <= 1'b0;
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench driving a skid and a non-skid instance with shared stimulus
module tb_pipe_stage_buf;
  localparam logic [7:0] MASK = 8'h0F;
  localparam logic [7:0] RSTV = 8'h5A;
  logic clk, rst_n;
  logic in_valid, out_ready, flush;
  logic [7:0] in_data;
  int checks, errors;
  logic [7:0] q [2][$];
  logic [7:0] last [2];
  logic [7:0] cur_out [2];
  logic ir_exp [2];
  logic ov [2], rdy [2];
  logic [7:0] od [2];
  logic [1:0] oc [2];
  int n;
  logic [7:0] eo;
  pipe_stage_buf_if #(.WIDTH(8)) bus0 ();
  pipe_stage_buf_if #(.WIDTH(8)) bus1 ();
  assign bus0.flush = flush;
  assign bus0.in_valid = in_valid;
  assign bus0.in_data = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.flush = flush;
  assign bus1.in_valid = in_valid;
  assign bus1.in_data = in_data;
  assign bus1.out_ready = out_ready;
  assign ov[0] = bus0.out_valid;
  assign rdy[0] = bus0.in_ready;
  assign od[0] = bus0.out_data;
  assign oc[0] = bus0.occupancy;
  assign ov[1] = bus1.out_valid;
  assign rdy[1] = bus1.in_ready;
  assign od[1] = bus1.out_data;
  assign oc[1] = bus1.occupancy;
  pipe_stage_buf #(.WIDTH(8), .SKID(1), .CLR_MASK(MASK), .RST_VAL(RSTV))
    u_skid (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pipe_stage_buf #(.WIDTH(8), .SKID(0), .CLR_MASK(MASK), .RST_VAL(RSTV))
    u_noskid (.clk(clk), .rst_n(rst_n), .bus(bus1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask
  // monitor: expected state is the in-order entry queue; pops on each handoff
  always @(negedge clk) begin
    #1;
    if (rst_n)
      for (int k = 0; k < 2; k++) begin
        n = q[k].size();
        eo = (n > 0) ? q[k][0] : last[k];
        ir_exp[k] = (k == 0) ? (n < 2) : (n == 0 || out_ready);
        cur_out[k] = eo;
        chk("out_valid", k, 8'(ov[k]), 8'(n > 0));
        chk("occupancy", k, 8'(oc[k]), 8'(n));
        chk("in_ready", k, 8'(rdy[k]), 8'(ir_exp[k]));
        chk("out_data", k, od[k], eo);
        if (n > 0 && out_ready) last[k] = q[k].pop_front();
      end
  end
  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    #2;
    for (int k = 0; k < 2; k++)
      if (fl) begin
        q[k].delete();
        last[k] = cur_out[k] & ~MASK;
      end else if (iv && ir_exp[k]) q[k].push_back(d);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      last[k] = RSTV;
      chk("rst_out_valid", k, 8'(ov[k]), 8'h00);
      chk("rst_occupancy", k, 8'(oc[k]), 8'h00);
      chk("rst_in_ready", k, 8'(rdy[k]), 8'h01);
      chk("rst_out_data", k, od[k], RSTV);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    in_data = 8'h00;
    for (int k = 0; k < 2; k++) begin
      last[k] = RSTV;
      cur_out[k] = RSTV;
      ir_exp[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'h0A, 1'b0, 1'b0);
    drive(1'b1, 8'h0B, 1'b0, 1'b0);
    drive(1'b1, 8'h0C, 1'b0, 1'b0);
    drive(1'b1, 8'h0C, 1'b1, 1'b0);
    repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'hF5, 1'b0, 1'b0);
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    do_reset();
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), 1'(($urandom % 100) == 0));
    repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed payload word of WIDTH bits between two pipeline stages using a valid/ready handshake.
- Optional 2-entry skid mode breaks the combinational stall path between stages.
- Flush clears only the payload bits selected by a mask (control bits such as RegWrite/MemWrite); datapath bits keep their values.

Parameters:
- WIDTH, 32: payload width in bits.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLR_MASK, {WIDTH{1'b1}}: payload bits forced to 0 on flush; bits at 0 in the mask hold their value.
- RST_VAL, {WIDTH{1'b0}}: out_data and skid data value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; kills all held entries.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  registered payload to downstream.
- occupancy  out  2  number of valid entries held (0..2).

Behaviour:
- Transfer rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Entries leave in arrival order; nothing is dropped or duplicated except by flush.
- Reset (rst_n=0, async): out_valid=0, skid_valid=0, out_data=RST_VAL, skid data=RST_VAL, occupancy=0, in_ready=1. Reset overrides flush and all handshakes.
- Path rules:
  - out_data is always driven from a register; there is no combinational path from in_data to out_data.
  - With SKID=1, there is no combinational path from out_ready to in_ready.
- SKID=1 states, encoded by (out_valid, skid_valid):
  - EMPTY (0,0): in_ready=1. in_fire -> HALF, main<=in_data.
  - HALF (1,0): in_ready=1.
    - in_fire & out_fire -> HALF, main<=in_data.
    - in_fire & !out_fire -> FULL, skid<=in_data, main held.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL (1,1): in_ready=0.
    - out_fire -> HALF, main<=skid.
    - Otherwise hold.
  - (0,1) is illegal and unreachable.
  - in_ready is a registered signal equal to !skid_valid.
- SKID=0:
  - in_ready = out_ready | !out_valid (combinational).
  - in_fire loads main and sets out_valid=1.
  - out_fire & !in_fire clears out_valid.
  - Skid register is absent; occupancy never exceeds 1.
- Flush (sync, priority over all handshakes):
  - Next cycle: out_valid=0, skid_valid=0, occupancy=0, in_ready=1.
  - out_data <= out_data & ~CLR_MASK; skid data likewise.
  - An in_valid present in the flush cycle is dropped, even if in_ready=1.
  - An out_fire in the flush cycle is still a valid handoff for the downstream stage; the block does not replay it.
- Idle data: when out_valid=0, out_data holds its last value (after any masked clear). Downstream qualifies it with out_valid.
- occupancy = out_valid + skid_valid, registered.
- Latency: 1 cycle from in_fire to out_valid in EMPTY. Full throughput is 1 entry/cycle while out_ready=1.
- Stall mapping for the core: a hazard-unit stall maps to out_ready=0 on the downstream side; a branch flush maps to flush.

Test Plan:
- Reset with rst_n=0 mid-stream while FULL -> out_valid=0, occupancy=0, in_ready=1, out_data=RST_VAL immediately; no entry appears after release.
- SKID=1, WIDTH=32, out_ready=1, in_valid=1 feeding 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles, 1 cycle behind, in_ready=1 throughout.
- SKID=1: feed 0xA, 0xB, 0xC with out_ready=0 -> 0xA in main, 0xB in skid, occupancy=2, in_ready=0, 0xC held upstream. Raise out_ready -> out_data sequence 0xA, 0xB, 0xC with no loss.
- Flush with WIDTH=8, CLR_MASK=8'h0F, FULL holding 8'hF5/8'h3C, in_valid=1 -> next cycle out_valid=0, occupancy=0, out_data=8'hF0, in_ready=1, flush-cycle input absent from output.
- SKID=0: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> new data accepted and out_valid stays 1.
- Random in_valid/out_ready (50%) for 10k cycles, with flush at 1% -> scoreboard: in-order, no duplicates, occupancy ≤ 2 (≤ 1 when SKID=0); with SKID=1, in_ready never changes combinationally with out_ready.
